// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if
//
// Bundles the two handshakes of the FIFO drain controller. The FIFO-side signals
// form the read port of the memory_core FIFO. The stream-side signals form the
// downstream valid/ready output.
//
// Parameters:
//   DW          data width, must equal the FIFO data width
//
// Signals:
//   fifo_empty  FIFO has no readable word             (environment -> controller)
//   fifo_ren    read enable into the FIFO             (controller  -> environment)
//   fifo_valid  fifo_data valid, one cycle after ren  (environment -> controller)
//   fifo_data   FIFO read data                        (environment -> controller)
//   out_valid   skid buffer head valid                (controller  -> environment)
//   out_data    skid buffer head word                 (controller  -> environment)
//   out_ready   downstream accepts                    (environment -> controller)
//
// Modports:
//   master      the drain controller
//   slave       the FIFO plus the downstream consumer
interface fifo_drain_ctrl_if #(
  parameter int DW = 16
) ();

  logic          fifo_empty;
  logic          fifo_ren;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output fifo_ren,
    output out_valid,
    output out_data,
    input  fifo_empty,
    input  fifo_valid,
    input  fifo_data,
    input  out_ready
  );

  modport slave (
    input  fifo_ren,
    input  out_valid,
    input  out_data,
    output fifo_empty,
    output fifo_valid,
    output fifo_data,
    output out_ready
  );

endinterface

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
//
// Read-side host controller for the memory_core FIFO. It issues read enables
// into the FIFO's one-cycle-latency read port. Returning words are captured
// into a small skid buffer and presented downstream as a valid/ready stream.
// Reads are only issued when the skid buffer is guaranteed to have room for
// the response, so back-pressure never drops a word. A start/abort burst FSM
// (IDLE -> RUN -> DRAIN) controls how many words are fetched.
//
// Build option:
//   FIFO_DRAIN_STATS_EN  when defined, adds the word_count port and counter.
//                        The counter counts every delivered word, wraps at
//                        16 bits and is cleared by rst only.
//
// Parameters:
//   DW          data width (must match the interface / FIFO)
//   SKID_DEPTH  skid buffer entries, power of two in 2..8
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   clk_en      global enable; every state update is qualified by it
//   start       begin a burst (honoured in IDLE only)
//   abort       stop issuing reads (honoured in RUN only)
//   burst_len   words per burst, latched on start; 0 = continuous until abort
//   bus         fifo_drain_ctrl_if.master (FIFO read port + output stream)
//   busy        controller is not IDLE
//   done        single-cycle pulse on the DRAIN -> IDLE transition
//   proto_err   sticky protocol error, cleared only by rst
//   word_count  delivered word count (FIFO_DRAIN_STATS_EN only)
module fifo_drain_ctrl #(
  parameter int DW         = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          burst_len,
  fifo_drain_ctrl_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                proto_err
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]         word_count
`endif
);

  // Pointer width and occupancy width. Occupancy needs one extra bit to
  // represent the completely full state.
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OW = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      len_q;
  logic [7:0]      issued;
  logic [7:0]      issued_nxt;
  logic            inflight;
  logic            post_rst;

  logic [DW-1:0]   skid [SKID_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;

  logic            ren;
  logic            credit_ok;
  logic            len_ok;
  logic            skid_full;
  logic            capture;
  logic            push;
  logic            pop;
  logic            err_set;
  logic            proto_err_q;

  // Credit check. The occupancy is taken before this cycle's pop and the
  // in-flight read is counted too, so a response always finds a free slot.
  assign credit_ok = ({1'b0, occ} + {{OW{1'b0}}, inflight}) < (OW+1)'(SKID_DEPTH);
  assign len_ok    = (len_q == 8'd0) || (issued < len_q);

  // The issued counter saturates so continuous mode can run indefinitely.
  // In burst mode it stops at len_q, so saturation is never reached.
  assign issued_nxt = (ren && (issued != 8'hFF)) ? issued + 8'd1 : issued;

  // Skid buffer handshakes. In the cycle right after reset, any response is
  // stale and is ignored completely.
  assign skid_full = (occ == OW'(SKID_DEPTH));
  assign capture   = clk_en && bus.fifo_valid && !post_rst;
  assign push      = capture && !skid_full;
  assign pop       = clk_en && (occ != '0) && bus.out_ready;
  assign err_set   = capture && (!inflight || skid_full);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic. The burst ends after the cycle whose issue brings the
  // count to burst_len. DRAIN waits until the last response has arrived and
  // every captured word has been handed downstream.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = DRAIN;
        end else if ((len_q != 8'd0) && (issued_nxt == len_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ == '0) && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs. The read enable is combinational and is suppressed in the
  // cycle abort is seen, while disabled, and while reset is asserted.
  always_comb begin
    busy = (state != IDLE);
    ren  = clk_en && !rst && (state == RUN) && !abort && !bus.fifo_empty &&
           credit_ok && len_ok;
    done = clk_en && !rst && (state == DRAIN) && (occ == '0) && !inflight;
  end

  assign bus.fifo_ren = ren;

  // Burst bookkeeping. The length is latched and the issued count is cleared
  // on start. The in-flight flag marks that a response is due next enabled
  // cycle. The post-reset flag masks the stale response slot after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= 8'd0;
      issued   <= 8'd0;
      inflight <= 1'b0;
      post_rst <= 1'b1;
    end else if (clk_en) begin
      inflight <= ren;
      post_rst <= 1'b0;
      if ((state == IDLE) && start) begin
        len_q  <= burst_len;
        issued <= 8'd0;
      end else if (state == RUN) begin
        issued <= issued_nxt;
      end
    end
  end

  // Skid buffer storage and pointers. A push into a full buffer is dropped
  // and leaves the pointers alone. Simultaneous push and pop keep occ steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        skid[wr_ptr] <= bus.fifo_data;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky protocol error: an unsolicited response, or a response with no
  // room in the skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (err_set) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;

  // The head of the skid buffer drives the output stream. The registers hold
  // while clk_en is low, so the stream holds as well.
  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = skid[rd_ptr];

`ifdef FIFO_DRAIN_STATS_EN
  // Delivered-word counter. It survives start and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= 16'd0;
    end else if (pop) begin
      word_count <= word_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl
//
// Self-checking bench for fifo_drain_ctrl (SKID_DEPTH = 2). A queue-based FIFO
// model answers read enables one cycle later. Expected words are pushed to a
// scoreboard when a burst is set up, and are popped and compared whenever the
// DUT hands a word downstream.
module tb_fifo_drain_ctrl;

  localparam int DW   = 16;
  localparam int SKID = 2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       clk_en    = 1'b1;
  logic       start     = 1'b0;
  logic       abort     = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       busy;
  logic       done;
  logic       proto_err;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] word_count;
`endif

  fifo_drain_ctrl_if #(.DW(DW)) bus ();

  fifo_drain_ctrl #(.DW(DW), .SKID_DEPTH(SKID)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .start     (start),
    .abort     (abort),
    .burst_len (burst_len),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .proto_err (proto_err)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model state and scoreboard
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic        model_valid  = 1'b0;
  logic [15:0] model_data   = 16'h0;
  logic        model_empty  = 1'b1;
  logic        hold_empty   = 1'b0;
  logic        inject_valid = 1'b0;
  logic [15:0] inject_data  = 16'h0;
  logic        ren_s        = 1'b0;

  int tests_run   = 0;
  int tests_failed = 0;
  int ren_count   = 0;
  int done_count  = 0;
  int pop_count   = 0;

  assign bus.fifo_valid = model_valid | inject_valid;
  assign bus.fifo_data  = inject_valid ? inject_data : model_data;
  assign bus.fifo_empty = model_empty;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Preload the FIFO model and scoreboard, then pulse start for one cycle.
  task automatic applyStimulus(input int nwords, input logic [15:0] base, input logic [7:0] len);
    for (int i = 0; i < nwords; i++) begin
      fifo_q.push_back(base + 16'(i));
      exp_q.push_back(base + 16'(i));
    end
    burst_len = len;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int d0;
    int i;
    d0 = done_count;
    i  = 0;
    while ((done_count == d0) && (i < budget)) begin
      tick(1);
      i++;
    end
    checkOutput(tag, 32'(done_count != d0), 32'd1);
  endtask

  // Monitor, sampled at the falling edge: counts reads and done pulses and
  // checks every delivered word against the scoreboard.
  always @(negedge clk) begin
    ren_s = 1'b0;
    if (!rst && clk_en) begin
      ren_s = bus.fifo_ren;
      if (bus.fifo_ren) ren_count++;
      if (done) done_count++;
      if (bus.out_valid && bus.out_ready) begin
        pop_count++;
        if (exp_q.size() == 0) checkOutput("unexpected_pop", 32'(bus.out_data), 32'hFFFF_FFFF);
        else checkOutput("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // FIFO model: one-cycle read latency, gated by the same clk_en.
  always @(posedge clk) begin
    if (rst) begin
      model_valid <= 1'b0;
    end else if (clk_en) begin
      if (ren_s && (fifo_q.size() != 0)) begin
        model_valid <= 1'b1;
        model_data  <= fifo_q.pop_front();
      end else begin
        model_valid <= 1'b0;
      end
    end
    model_empty <= hold_empty || (fifo_q.size() == 0);
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, r0, p0, seen;
    logic aborted;
    bus.out_ready = 1'b1;

    // Reset state
    tick(2);
    checkOutput("rst_fifo_ren", 32'(bus.fifo_ren), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_proto_err", 32'(proto_err), 32'd0);
`ifdef FIFO_DRAIN_STATS_EN
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
`endif
    rst = 1'b0;
    tick(1);

    // Basic burst with latency checks
    $display("[TB] basic burst");
    d0 = done_count;
    applyStimulus(4, 16'h0011, 8'd4);
    checkOutput("basic_busy_t1", 32'(busy), 32'd1);
    checkOutput("basic_ren_t1", 32'(bus.fifo_ren), 32'd1);
    tick(1);
    checkOutput("basic_fifo_valid_t2", 32'(bus.fifo_valid), 32'd1);
    checkOutput("basic_out_valid_t2", 32'(bus.out_valid), 32'd0);
    tick(1);
    checkOutput("basic_out_valid_t3", 32'(bus.out_valid), 32'd1);
    checkOutput("basic_out_data_t3", 32'(bus.out_data), 32'h0011);
    waitDone(60, "basic_done_seen");
    tick(4);
    checkOutput("basic_done_once", 32'(done_count - d0), 32'd1);
    checkOutput("basic_proto_err", 32'(proto_err), 32'd0);
    checkOutput("basic_idle", 32'(busy), 32'd0);
    checkOutput("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure with a clk_en freeze
    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    r0 = ren_count;
    p0 = pop_count;
    applyStimulus(6, 16'h0100, 8'd6);
    tick(9);
    checkOutput("bp_ren_while_stalled", 32'(ren_count - r0), 32'd2);
    checkOutput("bp_head_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    clk_en = 1'b0;
    #1;
    checkOutput("bp_freeze_ren", 32'(bus.fifo_ren), 32'd0);
    tick(3);
    checkOutput("bp_freeze_out_data", 32'(bus.out_data), 32'h0100);
    checkOutput("bp_freeze_no_pop", 32'(pop_count - p0), 32'd0);
    clk_en = 1'b1;
    waitDone(100, "bp_done_seen");
    checkOutput("bp_all_delivered", 32'(pop_count - p0), 32'd6);
    checkOutput("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty FIFO for the first cycles of the burst
    $display("[TB] empty fifo");
    hold_empty = 1'b1;
    r0 = ren_count;
    applyStimulus(2, 16'h0200, 8'd2);
    tick(4);
    checkOutput("empty_no_ren", 32'(ren_count - r0), 32'd0);
    checkOutput("empty_busy", 32'(busy), 32'd1);
    hold_empty = 1'b0;
    waitDone(60, "empty_done_seen");
    checkOutput("empty_ren_total", 32'(ren_count - r0), 32'd2);
    checkOutput("empty_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort in continuous mode on the fourth would-be read
    $display("[TB] abort");
    r0 = ren_count;
    applyStimulus(3, 16'h0300, 8'd0);
    for (int i = 0; i < 5; i++) fifo_q.push_back(16'h0E00 + 16'(i));
    seen = 0;
    aborted = 1'b0;
    for (int i = 0; (i < 60) && !aborted; i++) begin
      if (bus.fifo_ren) begin
        if (seen == 3) begin
          abort = 1'b1;
          #1;
          checkOutput("abort_ren_suppressed", 32'(bus.fifo_ren), 32'd0);
          aborted = 1'b1;
        end else begin
          seen++;
        end
      end
      tick(1);
      abort = 1'b0;
    end
    checkOutput("abort_reached", 32'(aborted), 32'd1);
    waitDone(60, "abort_done_seen");
    tick(3);
    checkOutput("abort_ren_total", 32'(ren_count - r0), 32'd3);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    checkOutput("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    fifo_q.delete();
    tick(2);

    // Reset while two words sit in the skid buffer
    $display("[TB] reset mid-burst");
    bus.out_ready = 1'b0;
    applyStimulus(2, 16'h0400, 8'd2);
    tick(5);
    checkOutput("rstmid_out_valid_before", 32'(bus.out_valid), 32'd1);
    checkOutput("rstmid_head_before", 32'(bus.out_data), 32'h0400);
`ifdef FIFO_DRAIN_STATS_EN
    checkOutput("stats_count_before", 32'(word_count), 32'd15);
`endif
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    checkOutput("rstmid_out_valid_after", 32'(bus.out_valid), 32'd0);
    checkOutput("rstmid_busy_after", 32'(busy), 32'd0);
    inject_valid = 1'b1;
    inject_data  = 16'hDEAD;
    tick(1);
    inject_valid = 1'b0;
    checkOutput("rstmid_stale_no_err", 32'(proto_err), 32'd0);
    checkOutput("rstmid_stale_no_push", 32'(bus.out_valid), 32'd0);
`ifdef FIFO_DRAIN_STATS_EN
    checkOutput("stats_count_after", 32'(word_count), 32'd0);
`endif
    bus.out_ready = 1'b1;
    tick(2);

    // Unsolicited response in IDLE
    $display("[TB] protocol error");
    exp_q.push_back(16'hBEEF);
    inject_valid = 1'b1;
    inject_data  = 16'hBEEF;
    tick(1);
    inject_valid = 1'b0;
    checkOutput("perr_set", 32'(proto_err), 32'd1);
    tick(5);
    checkOutput("perr_sticky", 32'(proto_err), 32'd1);
    checkOutput("perr_word_delivered", 32'(exp_q.size()), 32'd0);
    checkOutput("perr_still_idle", 32'(busy), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("perr_cleared_by_rst", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
